// File: rtl/sumser2b.sv
// sumser2b: digit-serial W-bit adder driven through a single 2-bit adder
// slice (sum2b). Operands are shifted through the slice low digit first,
// with the slice carry fed back through a carry register. The completed
// sum and final carry are registered and flagged with a one-cycle done pulse.
//
// Handshake: start is a request sampled only while idle (busy=0, done=0);
// a, b and ci are captured on the same edge that accepts it. There is no
// back-pressure: done is a single-cycle strobe, and so/co stay valid from
// that cycle until the next completion.

// 2-bit ripple full-adder slice: {co_o, s_o} = a_i + b_i + ci_i.
module sum2b (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic       ci_i,
    output logic [1:0] s_o,
    output logic       co_o
);
    logic c1;

    // Two chained full adders; c1 is the carry between the digit bits.
    always_comb begin
        s_o[0] = a_i[0] ^ b_i[0] ^ ci_i;
        c1     = (a_i[0] & b_i[0]) | (ci_i & (a_i[0] ^ b_i[0]));
        s_o[1] = a_i[1] ^ b_i[1] ^ c1;
        co_o   = (a_i[1] & b_i[1]) | (c1 & (a_i[1] ^ b_i[1]));
    end
endmodule

module sumser2b #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] so,
    output logic         co,
    output logic [1:0]   dbg_state
);
    // Digit counter only needs to reach W/2-1; keep at least one bit.
    localparam int              CW   = (W > 2) ? $clog2(W / 2) : 1;
    localparam logic [CW-1:0]   LAST = CW'(W / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   ra_q, ra_d;
    logic [W-1:0]   rb_q, rb_d;
    logic           cr_q, cr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   so_q, so_d;
    logic           co_q, co_d;

    logic [1:0]     slice_s;
    logic           slice_co;
    // rs_full is the result shift register after this cycle's shift-in:
    // the new digit in the top two bits, earlier digits below it.
    logic [W-1:0]   rs_full;

    sum2b u_slice (
        .a_i  (ra_q[1:0]),
        .b_i  (rb_q[1:0]),
        .ci_i (cr_q),
        .s_o  (slice_s),
        .co_o (slice_co)
    );

    // Result shift register. Its lowest digit would only ever hold a value
    // that is shifted out before use, so only the top W-2 bits are stored;
    // for W=2 the single slice digit is the whole result.
    generate
        if (W > 2) begin : g_rs
            logic [W-3:0] rs_q, rs_d;

            assign rs_full = {slice_s, rs_q};

            // Shift in a new digit every RUN cycle, hold otherwise.
            always_comb begin
                rs_d = rs_q;
                if (state_q == S_RUN) begin
                    rs_d = rs_full[W-1:2];
                end
            end

            // Result shift register storage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rs_q <= '0;
                end else begin
                    rs_q <= rs_d;
                end
            end
        end else begin : g_rs_min
            assign rs_full = slice_s;
        end
    endgenerate

    // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        cr_d    = cr_q;
        cnt_d   = cnt_q;
        so_d    = so_q;
        co_d    = co_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    cr_d    = ci;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                ra_d  = ra_q >> 2;
                rb_d  = rb_q >> 2;
                cr_d  = slice_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Last digit: publish the whole sum in one step so the
                    // outputs never expose a partial result.
                    so_d    = rs_full;
                    co_d    = slice_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand, carry, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            cr_q    <= 1'b0;
            cnt_q   <= '0;
            so_q    <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            cr_q    <= cr_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            co_q    <= co_d;
        end
    end

    // Status outputs decode directly from the state register.
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign so        = so_q;
    assign co        = co_q;
    assign dbg_state = state_q;
endmodule
